task_frame_loader: RTL and testbench
====================================

TASK_FRAME_LOADER -- requirements
Module: task_frame_loader

Interface
REQ-001 Parameter FRAME_W, default 128, width of one task-memory frame in bits.
REQ-002 Parameter DEPTH, default 64, frames per bank (power of two, >=2); ADDR_W = log2(DEPTH).
REQ-003 clk  in  1  clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 host_valid  in  1  host frame present.
REQ-006 host_ready  out  1  loader accepts frame this cycle.
REQ-007 host_data  in  FRAME_W  frame payload.
REQ-008 host_last  in  1  marks final frame of a task program.
REQ-009 ts_rd_addr  in  ADDR_W  scheduler read address into active bank.
REQ-010 ts_rd_data  out  FRAME_W  frame at ts_rd_addr, registered.
REQ-011 ts_start  out  1  one-cycle pulse: new bank made active.
REQ-012 ts_done  in  1  scheduler releases active bank (pulse).
REQ-013 ts_len  out  ADDR_W+1  frame count of active bank.
REQ-014 active_bank  out  1  index of bank being executed.
REQ-015 err_overflow  out  1  sticky: program exceeded DEPTH frames.
REQ-016 perf_stall_cnt  out  32  host stall cycle count (see Configuration).

Function
REQ-017 Two banks (0,1), each DEPTH x FRAME_W; each SHALL hold state EMPTY, FILLING, FULL or ACTIVE.
REQ-018 Write pointer wb selects the fill bank; transfer occurs when host_valid & host_ready.
REQ-019 host_ready SHALL be 1 iff bank[wb] is EMPTY or FILLING.
REQ-020 First transfer into EMPTY bank: EMPTY->FILLING, frame written at address 0; later frames at incrementing addresses.
REQ-021 Transfer with host_last: bank -> FULL, length latched (1..DEPTH), wb toggles.
REQ-022 Transfer when write address = DEPTH-1 without host_last: frame written, err_overflow set, later frames dropped (host_ready stays 1) until host_last, then bank -> EMPTY, wb unchanged.
REQ-023 No bank ACTIVE and a bank FULL: that bank -> ACTIVE next cycle, ts_start pulses 1 cycle, active_bank/ts_len updated same cycle; if both FULL, bank with older completion first.
REQ-024 ts_done while a bank ACTIVE: bank -> EMPTY next cycle; ts_done with no ACTIVE bank SHALL be ignored.
REQ-025 ts_done and activation of the other FULL bank SHALL not occur in the same cycle; activation follows one cycle after release (ts_start earliest 2 cycles after ts_done).
REQ-026 Same-cycle host transfer into a bank and its release by ts_done cannot collide (different banks); the bank freed by ts_done SHALL be writable from the next cycle.
REQ-027 ts_rd_data SHALL equal bank[active_bank][ts_rd_addr] one cycle after address presented; addresses >= ts_len return undefined data.

Reset
REQ-028 Reset SHALL set both banks EMPTY, wb=0, active_bank=0, ts_len=0, ts_start=0, err_overflow=0, perf_stall_cnt=0; memory contents not cleared.
REQ-029 Reset mid-fill or mid-execution SHALL abandon the program; host_ready=1 the cycle after reset deasserts.

Configuration
REQ-030 Macro TFL_PERF_CNT_EN defined: perf_stall_cnt increments (saturating at 2^32-1) each cycle host_valid & ~host_ready.
REQ-031 Macro undefined: perf_stall_cnt tied to 0, no counter logic.

Structure
REQ-032 Bank state encoding and default FRAME_W/DEPTH SHALL live in the shared definitions include.
REQ-033 One sub-module tfl_bank (single-bank RAM, write port, registered read port) instantiated twice.

Verification
REQ-034 Load 3-frame program (last on 3rd) -> ts_start pulse, ts_len=3, active_bank=0, reads at addr 0..2 return frames after 1 cycle.
REQ-035 Load two programs while bank 0 active -> bank 1 FULL, third program sees host_ready=0 until ts_done; ts_start for bank 1 two cycles after ts_done.
REQ-036 DEPTH=64, send 70 frames, last on 70th -> err_overflow=1, no ts_start, bank 0 EMPTY, next program loads into bank 0.
REQ-037 Assert reset during fill of frame 10 -> all outputs at reset values, host_ready=1 next cycle.
REQ-038 TFL_PERF_CNT_EN defined, host_valid held 5 cycles with host_ready=0 -> perf_stall_cnt=5; undefined -> stays 0.

Source files
------------

// File: rtl/task_frame_loader_pkg.sv
// Shared definitions for the task frame loader: bank state encoding and default geometry.
package task_frame_loader_pkg;

  localparam int TFL_FRAME_W = 128;
  localparam int TFL_DEPTH   = 64;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_ACTIVE  = 2'd3
  } bank_state_t;

endpackage

// File: rtl/task_frame_loader_if.sv
// Host-side frame streaming handshake between a program source and the loader.
interface task_frame_loader_if
  import task_frame_loader_pkg::*;
#(
  parameter int FRAME_W = TFL_FRAME_W
);
  logic               host_valid;
  logic               host_ready;
  logic [FRAME_W-1:0] host_data;
  logic               host_last;

  modport master (output host_valid, host_data, host_last, input host_ready);
  modport slave  (input host_valid, host_data, host_last, output host_ready);
endinterface

// File: rtl/tfl_bank.sv
// One task-memory bank: DEPTH x FRAME_W storage, single write port, registered read port.
module tfl_bank #(
  parameter int  FRAME_W = 128,
  parameter int  DEPTH   = 64,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [FRAME_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [FRAME_W-1:0] rdata
);

  logic [FRAME_W-1:0] mem [DEPTH];

  // NOTE: storage and read register are deliberately not reset, so this maps onto plain block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/task_frame_loader.sv
// Double-banked task program loader: host fills one bank while the scheduler executes the other.
// Optional feature: define TFL_PERF_CNT_EN to build the saturating host stall counter.
module task_frame_loader
  import task_frame_loader_pkg::*;
#(
  parameter int  FRAME_W = TFL_FRAME_W,
  parameter int  DEPTH   = TFL_DEPTH,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  task_frame_loader_if.slave  host,
  input  logic [ADDR_W-1:0]   ts_rd_addr,
  output logic [FRAME_W-1:0]  ts_rd_data,
  output logic                ts_start,
  input  logic                ts_done,
  output logic [ADDR_W:0]     ts_len,
  output logic                active_bank,
  output logic                err_overflow,
  output logic [31:0]         perf_stall_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bank_state_t        state_q [2];
  bank_state_t        state_d [2];
  logic [ADDR_W:0]    len_q [2];
  logic [ADDR_W:0]    len_d [2];
  logic               wb_q, wb_d;
  logic               drop_q, drop_d;
  logic               active_q, active_d;
  logic               start_q, start_d;
  logic               ovf_q, ovf_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [ADDR_W:0]    ts_len_q, ts_len_d;
  logic [1:0]         wr_en;
  logic               pick;
  logic               ready;
  logic               xfer;
  logic [FRAME_W-1:0] rd_data [2];

  assign ready          = (state_q[wb_q] == BANK_EMPTY) || (state_q[wb_q] == BANK_FILLING);
  assign xfer           = host.host_valid && ready;
  assign host.host_ready = ready;

  // NOTE: every signal written here takes its held value first, so no branch can infer a latch.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wb_d     = wb_q;
    drop_d   = drop_q;
    active_d = active_q;
    start_d  = 1'b0;
    ovf_d    = ovf_q;
    waddr_d  = waddr_q;
    ts_len_d = ts_len_q;
    wr_en    = '0;
    pick     = wb_q;

    // Fill side: only touches bank[wb], which is never FULL or ACTIVE here.
    if (xfer) begin
      if (drop_q) begin
        // Overflowed program: swallow frames until its end, then discard the bank.
        if (host.host_last) begin
          state_d[wb_q] = BANK_EMPTY;
          drop_d        = 1'b0;
          waddr_d       = '0;
        end
      end else begin
        wr_en[wb_q]   = 1'b1;
        state_d[wb_q] = BANK_FILLING;
        if (host.host_last) begin
          state_d[wb_q] = BANK_FULL;
          len_d[wb_q]   = {1'b0, waddr_q} + (ADDR_W + 1)'(1);
          wb_d          = ~wb_q;
          waddr_d       = '0;
        end else if (waddr_q == LAST_ADDR) begin
          ovf_d  = 1'b1;
          drop_d = 1'b1;
        end else begin
          waddr_d = waddr_q + ADDR_W'(1);
        end
      end
    end

    // Execute side: release and activation are mutually exclusive, giving the one-cycle gap.
    if (state_q[active_q] == BANK_ACTIVE) begin
      if (ts_done) state_d[active_q] = BANK_EMPTY;
    end else if (state_q[wb_q] == BANK_FULL || state_q[~wb_q] == BANK_FULL) begin
      // With both FULL, bank[wb] completed first since wb toggled past it.
      pick          = (state_q[wb_q] == BANK_FULL) ? wb_q : ~wb_q;
      state_d[pick] = BANK_ACTIVE;
      active_d      = pick;
      ts_len_d      = len_q[pick];
      start_d       = 1'b1;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= '{BANK_EMPTY, BANK_EMPTY};
      len_q    <= '{default: '0};
      wb_q     <= 1'b0;
      drop_q   <= 1'b0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      ovf_q    <= 1'b0;
      waddr_q  <= '0;
      ts_len_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wb_q     <= wb_d;
      drop_q   <= drop_d;
      active_q <= active_d;
      start_q  <= start_d;
      ovf_q    <= ovf_d;
      waddr_q  <= waddr_d;
      ts_len_q <= ts_len_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tfl_bank #(.FRAME_W(FRAME_W), .DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .we    (wr_en[b]),
      .waddr (waddr_q),
      .wdata (host.host_data),
      .raddr (ts_rd_addr),
      .rdata (rd_data[b])
    );
  end

  assign ts_rd_data   = rd_data[active_q];
  assign ts_start     = start_q;
  assign ts_len       = ts_len_q;
  assign active_bank  = active_q;
  assign err_overflow = ovf_q;

`ifdef TFL_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (host.host_valid && !ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_task_frame_loader.sv
// Self-checking bench for task_frame_loader: table-driven first program, read scoreboard, corner sequences.
module tb_task_frame_loader;

  localparam int FRAME_W = 128;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 6;

`ifdef TFL_PERF_CNT_EN
  localparam int EXP_STALLS = 5;
`else
  localparam int EXP_STALLS = 0;
`endif

  typedef logic [FRAME_W-1:0] val_t;

  typedef struct {
    val_t data;
    logic last;
    logic exp_ready;
    logic exp_start;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] ts_rd_addr;
  val_t              ts_rd_data;
  logic              ts_start;
  logic              ts_done;
  logic [ADDR_W:0]   ts_len;
  logic              active_bank;
  logic              err_overflow;
  logic [31:0]       perf_stall_cnt;

  int   n_checks   = 0;
  int   n_fails    = 0;
  int   ready_miss = 0;
  val_t model_mem [2][DEPTH];
  val_t exp_q [$];

  task_frame_loader_if #(.FRAME_W(FRAME_W)) host_if ();

  task_frame_loader #(.FRAME_W(FRAME_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .host           (host_if),
    .ts_rd_addr     (ts_rd_addr),
    .ts_rd_data     (ts_rd_data),
    .ts_start       (ts_start),
    .ts_done        (ts_done),
    .ts_len         (ts_len),
    .active_bank    (active_bank),
    .err_overflow   (err_overflow),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input val_t act, input val_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One frame offered for exactly one cycle; readiness misses are tallied for later checks.
  task automatic send(input int bank, input int idx, input logic last);
    val_t d;
    d = {$urandom, $urandom, $urandom, $urandom};
    host_if.host_valid = 1'b1;
    host_if.host_data  = d;
    host_if.host_last  = last;
    if (host_if.host_ready !== 1'b1) ready_miss++;
    if (idx < DEPTH) model_mem[bank][idx] = d;
    tick();
    host_if.host_valid = 1'b0;
    host_if.host_last  = 1'b0;
  endtask

  task automatic read_check(input int bank, input int addr, input string name);
    val_t exp;
    ts_rd_addr = addr[ADDR_W-1:0];
    exp_q.push_back(model_mem[bank][addr]);
    tick();
    if (exp_q.size() == 0) begin
      check({name, "_empty_queue"}, val_t'(0), val_t'(1));
    end else begin
      exp = exp_q.pop_front();
      check(name, ts_rd_data, exp);
    end
  endtask

  task automatic release_bank();
    ts_done = 1'b1;
    tick();
    ts_done = 1'b0;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    host_if.host_valid = 1'b0;
    host_if.host_last  = 1'b0;
    ts_done            = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vec_t prog1 [3];
    logic saw_start;

    for (int i = 0; i < 3; i++) begin
      prog1[i].data      = {$urandom, $urandom, $urandom, $urandom};
      prog1[i].last      = (i == 2);
      prog1[i].exp_ready = 1'b1;
      prog1[i].exp_start = 1'b0;
    end

    host_if.host_data = '0;
    ts_rd_addr        = '0;
    do_reset();

    check("rst_ready",  val_t'(host_if.host_ready), val_t'(1));
    check("rst_start",  val_t'(ts_start),           val_t'(0));
    check("rst_len",    val_t'(ts_len),             val_t'(0));
    check("rst_ovf",    val_t'(err_overflow),       val_t'(0));
    check("rst_perf",   val_t'(perf_stall_cnt),     val_t'(0));

    // Three-frame program into bank 0, driven from the vector table.
    for (int i = 0; i < 3; i++) begin
      host_if.host_valid = 1'b1;
      host_if.host_data  = prog1[i].data;
      host_if.host_last  = prog1[i].last;
      check($sformatf("p1_ready[%0d]", i), val_t'(host_if.host_ready), val_t'(prog1[i].exp_ready));
      check($sformatf("p1_start[%0d]", i), val_t'(ts_start),           val_t'(prog1[i].exp_start));
      model_mem[0][i] = prog1[i].data;
      tick();
    end
    host_if.host_valid = 1'b0;
    host_if.host_last  = 1'b0;
    check("p1_start_early", val_t'(ts_start), val_t'(0));
    tick();
    check("p1_start", val_t'(ts_start),    val_t'(1));
    check("p1_len",   val_t'(ts_len),      val_t'(3));
    check("p1_bank",  val_t'(active_bank), val_t'(0));
    tick();
    check("p1_start_pulse", val_t'(ts_start), val_t'(0));
    for (int a = 0; a < 3; a++) read_check(0, a, $sformatf("p1_rd[%0d]", a));

    // Second program fills bank 1 while bank 0 executes; third program must stall.
    send(1, 0, 1'b0);
    send(1, 1, 1'b1);
    check("p2_ready_miss", val_t'(ready_miss), val_t'(0));
    tick();
    check("p2_no_start", val_t'(ts_start), val_t'(0));
    host_if.host_valid = 1'b1;
    host_if.host_data  = {$urandom, $urandom, $urandom, $urandom};
    host_if.host_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("p3_blocked[%0d]", k), val_t'(host_if.host_ready), val_t'(0));
      tick();
    end
    host_if.host_valid = 1'b0;
    host_if.host_last  = 1'b0;
    check("perf_stall", val_t'(perf_stall_cnt), val_t'(EXP_STALLS));
    release_bank();
    check("rel_gap_start", val_t'(ts_start),           val_t'(0));
    check("rel_ready",     val_t'(host_if.host_ready), val_t'(1));
    tick();
    check("b1_start", val_t'(ts_start),    val_t'(1));
    check("b1_bank",  val_t'(active_bank), val_t'(1));
    check("b1_len",   val_t'(ts_len),      val_t'(2));
    read_check(1, 0, "b1_rd0");
    read_check(1, 1, "b1_rd1");

    // Third program into the freed bank 0, activated only after bank 1 is released.
    send(0, 0, 1'b1);
    tick();
    check("p3_no_start", val_t'(ts_start), val_t'(0));
    release_bank();
    tick();
    check("p3_start", val_t'(ts_start),    val_t'(1));
    check("p3_bank",  val_t'(active_bank), val_t'(0));
    check("p3_len",   val_t'(ts_len),      val_t'(1));
    read_check(0, 0, "p3_rd0");
    release_bank();
    tick();

    // ts_done with nothing active must be ignored.
    release_bank();
    tick();
    check("idle_done_start", val_t'(ts_start),           val_t'(0));
    check("idle_done_ready", val_t'(host_if.host_ready), val_t'(1));

    // Reset in the middle of execution (bank 1) and fill (frame 10 of bank 0).
    send(1, 0, 1'b0);
    send(1, 1, 1'b1);
    tick();
    check("d_start", val_t'(ts_start),    val_t'(1));
    check("d_bank",  val_t'(active_bank), val_t'(1));
    for (int i = 0; i < 9; i++) send(0, i, 1'b0);
    host_if.host_valid = 1'b1;
    host_if.host_last  = 1'b0;
    reset              = 1'b1;
    tick();
    reset              = 1'b0;
    host_if.host_valid = 1'b0;
    check("mr_start", val_t'(ts_start),           val_t'(0));
    check("mr_len",   val_t'(ts_len),             val_t'(0));
    check("mr_bank",  val_t'(active_bank),        val_t'(0));
    check("mr_ovf",   val_t'(err_overflow),       val_t'(0));
    check("mr_perf",  val_t'(perf_stall_cnt),     val_t'(0));
    check("mr_ready", val_t'(host_if.host_ready), val_t'(1));
    tick();
    check("mr_ready_next", val_t'(host_if.host_ready), val_t'(1));
    check("mr_no_start",   val_t'(ts_start),           val_t'(0));

    // Program of exactly DEPTH frames is legal.
    for (int i = 0; i < DEPTH; i++) send(0, i, i == DEPTH - 1);
    check("max_ready_miss", val_t'(ready_miss), val_t'(0));
    tick();
    check("max_start", val_t'(ts_start),     val_t'(1));
    check("max_len",   val_t'(ts_len),       val_t'(DEPTH));
    check("max_bank",  val_t'(active_bank),  val_t'(0));
    check("max_ovf",   val_t'(err_overflow), val_t'(0));
    read_check(0, 0,         "max_rd_first");
    read_check(0, DEPTH - 1, "max_rd_last");
    release_bank();

    // 70-frame program overflows bank 0 and is discarded.
    do_reset();
    for (int i = 0; i < 70; i++) send(0, i, i == 69);
    check("ovf_ready_miss", val_t'(ready_miss), val_t'(0));
    saw_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      saw_start |= ts_start;
      tick();
    end
    check("ovf_flag",     val_t'(err_overflow),       val_t'(1));
    check("ovf_no_start", val_t'(saw_start),          val_t'(0));
    check("ovf_ready",    val_t'(host_if.host_ready), val_t'(1));
    send(0, 0, 1'b0);
    send(0, 1, 1'b1);
    tick();
    check("post_ovf_start",  val_t'(ts_start),     val_t'(1));
    check("post_ovf_bank",   val_t'(active_bank),  val_t'(0));
    check("post_ovf_len",    val_t'(ts_len),       val_t'(2));
    check("post_ovf_sticky", val_t'(err_overflow), val_t'(1));
    read_check(0, 0, "post_ovf_rd0");
    read_check(0, 1, "post_ovf_rd1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
